// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage with a load-wait FSM and load formatting.
// Define WB_CSR_EN to enable the CSR read-modify-write path for SYSTEM ops.
module reg_writeback #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] rd_data_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] csr_data_in,
  input  logic [11:0] csr_addr_in,
  input  logic [4:0]  uimm_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        stall,
  output logic        load_err
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] ld_f3;
  logic [4:0] ld_rd;
  logic [1:0] ld_off;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic ld_ok, ld_mis;
  logic is_alu, is_csr, sample, rf_en_nx, err_nx;
  logic [4:0] rf_addr_nx;
  logic [31:0] rf_data_nx;
  assign stall = state == WAIT_LOAD;
  assign sample = !halt && state == IDLE;
  assign is_alu = opcode_in inside {OP_IMM, OP_AUIPC, OP_OP, OP_LUI, OP_JALR, OP_JAL};
  always_comb begin
    ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_mis = (ld_f3[1:0] == 2'b01 && ld_off[0]) || (ld_f3 == 3'b010 && ld_off != 2'b00);
    ld_ok = 1'b1;
    case (ld_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: begin
        ld_data = mem_rdata;
        ld_ok = 1'b0;
      end
    endcase
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    err_nx = load_err;
    rf_en_nx = 1'b0;
    rf_addr_nx = rf_wr_addr;
    rf_data_nx = rf_wr_data;
    if (sample) begin
      rf_addr_nx = rd_addr_in;
      rf_data_nx = is_csr ? csr_data_in : rd_data_in;
      rf_en_nx = (is_alu || is_csr) && rd_addr_in != 5'd0;
      if (opcode_in == OP_LOAD) begin
        state_nx = WAIT_LOAD;
        cnt_nx = '0;
      end
    end else if (!halt && mem_rvalid) begin
      state_nx = IDLE;
      rf_addr_nx = ld_rd;
      rf_data_nx = ld_data;
      rf_en_nx = ld_ok && !ld_mis && ld_rd != 5'd0;
      err_nx = load_err | ld_mis;
    end else if (!halt && cnt == CW'(LOAD_TIMEOUT - 1)) begin
      state_nx = IDLE;
      err_nx = 1'b1;
    end else if (!halt) begin
      cnt_nx = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      load_err <= 1'b0;
      rf_wr_en <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      ld_f3 <= '0;
      ld_rd <= '0;
      ld_off <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      load_err <= err_nx;
      rf_wr_en <= rf_en_nx;
      rf_wr_addr <= rf_addr_nx;
      rf_wr_data <= rf_data_nx;
      if (sample && opcode_in == OP_LOAD) begin
        ld_f3 <= funct3_in;
        ld_rd <= rd_addr_in;
        ld_off <= rd_data_in[1:0];
      end
    end
  end
`ifdef WB_CSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  logic [31:0] csr_src, csr_new;
  logic csr_we;
  assign is_csr = opcode_in == OP_SYSTEM && funct3_in[1:0] != 2'b00;
  // set/clear with a zero source field leave the CSR untouched, so no strobe
  assign csr_we = is_csr && (funct3_in[1:0] == 2'b01 || uimm_in != 5'd0);
  assign csr_src = funct3_in[2] ? {27'd0, uimm_in} : rd_data_in;
  assign csr_new = funct3_in[1:0] == 2'b01 ? csr_src :
                   funct3_in[1:0] == 2'b10 ? csr_data_in | csr_src : csr_data_in & ~csr_src;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_wr_en <= 1'b0;
      csr_wr_addr <= '0;
      csr_wr_data <= '0;
    end else begin
      csr_wr_en <= sample && csr_we;
      if (sample && is_csr) begin
        csr_wr_addr <= csr_addr_in;
        csr_wr_data <= csr_new;
      end
    end
  end
`else
  logic unused_csr;
  assign is_csr = 1'b0;
  assign unused_csr = ^{csr_data_in, csr_addr_in, uimm_in};
  assign csr_wr_en = 1'b0;
  assign csr_wr_addr = '0;
  assign csr_wr_data = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenario tests for reg_writeback.
module tb_reg_writeback;
  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, MISC = 7'h0F;
  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LUI = 7'h37, AUIPC = 7'h17;
  localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, SYS = 7'h73, NOP = 7'h00;
  logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0, mem_rvalid = 1'b0;
  logic [6:0] opcode_in = '0;
  logic [2:0] funct3_in = '0;
  logic [31:0] rd_data_in = '0, csr_data_in = '0, mem_rdata = '0;
  logic [4:0] rd_addr_in = '0, uimm_in = '0;
  logic [11:0] csr_addr_in = '0;
  logic rf_wr_en, csr_wr_en, stall, load_err;
  logic [4:0] rf_wr_addr;
  logic [31:0] rf_wr_data, csr_wr_data;
  logic [11:0] csr_wr_addr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  reg_writeback dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .opcode_in(opcode_in), .funct3_in(funct3_in),
    .rd_data_in(rd_data_in), .rd_addr_in(rd_addr_in), .csr_data_in(csr_data_in),
    .csr_addr_in(csr_addr_in), .uimm_in(uimm_in), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .csr_wr_en(csr_wr_en),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data), .stall(stall), .load_err(load_err)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] d, input logic [4:0] rd);
    opcode_in = op;
    funct3_in = f3;
    rd_data_in = d;
    rd_addr_in = rd;
  endtask
  task automatic test_reset;
    drive(OPIMM, 3'd0, 32'h55, 5'd5);
    step;
    step;
    checks++; if ({rf_wr_en, csr_wr_en, stall, load_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rf_wr_en, csr_wr_en, stall, load_err}); end
    checks++; if ({rf_wr_addr, rf_wr_data} !== 37'd0) begin errors++; $display("FAIL reset_rf: got %h/%h expected 0/0", rf_wr_addr, rf_wr_data); end
    checks++; if ({csr_wr_addr, csr_wr_data} !== 44'd0) begin errors++; $display("FAIL reset_csr: got %h/%h expected 0/0", csr_wr_addr, csr_wr_data); end
    #2 rst_n = 1'b1;
    step;
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'h55) begin errors++; $display("FAIL reset_release: got en=%b data=%h expected 1/00000055", rf_wr_en, rf_wr_data); end
    drive(NOP, 3'd0, 32'd0, 5'd0);
    step;
  endtask
  task automatic test_alu;
    logic [6:0] ops [10];
    logic [9:0] wr;
    ops = '{OPIMM, OP, LUI, AUIPC, JAL, JALR, STORE, BRANCH, MISC, 7'h7F};
    wr = 10'b0000111111;
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], 3'd0, 32'h1000 + i, 5'(i + 1));
      step;
      checks++; if (rf_wr_en !== wr[i]) begin errors++; $display("FAIL alu_en[%0d]: got %b expected %b", i, rf_wr_en, wr[i]); end
      if (wr[i]) begin
        checks++; if (rf_wr_addr !== 5'(i + 1) || rf_wr_data !== 32'h1000 + i) begin errors++; $display("FAIL alu_wr[%0d]: got %0d/%h expected %0d/%h", i, rf_wr_addr, rf_wr_data, i + 1, 32'h1000 + i); end
      end
    end
    drive(OPIMM, 3'd0, 32'h0000_1234, 5'd5);
    step;
    checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin errors++; $display("FAIL addi: got %b/%0d/%h expected 1/5/00001234", rf_wr_en, rf_wr_addr, rf_wr_data); end
    drive(NOP, 3'd0, 32'd0, 5'd0);
    step;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL addi_pulse: got %b expected 0", rf_wr_en); end
    drive(OPIMM, 3'd0, 32'h0000_1234, 5'd0);
    step;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL addi_x0: got %b expected 0", rf_wr_en); end
    drive(OPIMM, 3'd0, 32'h0000_1234, 5'd5);
    halt = 1'b1;
    step;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL halt_idle: got %b expected 0", rf_wr_en); end
    halt = 1'b0;
    drive(NOP, 3'd0, 32'd0, 5'd0);
    step;
  endtask
  task automatic test_load;
    logic [2:0] f3 [7];
    logic [1:0] off [7];
    logic [31:0] rdat [7], exp_d [7];
    logic [6:0] wen;
    int w [7];
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
    off = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    rdat = '{32'h0080_0000, 32'h0080_0000, 32'h8001_1234, 32'h8001_F234, 32'hDEAD_BEEF, 32'h0000_7F00, 32'h1234_5678};
    exp_d = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F234, 32'hDEAD_BEEF, 32'h0000_007F, 32'h0};
    wen = 7'b0111111;
    w = '{3, 1, 2, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive(LOAD, f3[i], {30'h0400_0000, off[i]}, 5'(7 + i));
      step;
      checks++; if (stall !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL load_enter[%0d]: got stall=%b en=%b expected 1/0", i, stall, rf_wr_en); end
      drive(OPIMM, 3'd0, 32'hBAD, 5'd9);
      mem_rdata = rdat[i];
      for (int k = 1; k < w[i]; k++) begin
        step;
        checks++; if (stall !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL load_wait[%0d]: got stall=%b en=%b expected 1/0", i, stall, rf_wr_en); end
      end
      mem_rvalid = 1'b1;
      step;
      mem_rvalid = 1'b0;
      drive(NOP, 3'd0, 32'd0, 5'd0);
      checks++; if ({stall, rf_wr_en, load_err} !== {1'b0, wen[i], 1'b0}) begin errors++; $display("FAIL load_done[%0d]: got stall/en/err=%b expected 0%b0", i, {stall, rf_wr_en, load_err}, wen[i]); end
      if (wen[i]) begin
        checks++; if (rf_wr_addr !== 5'(7 + i) || rf_wr_data !== exp_d[i]) begin errors++; $display("FAIL load_data[%0d]: got %0d/%h expected %0d/%h", i, rf_wr_addr, rf_wr_data, 7 + i, exp_d[i]); end
      end
    end
    step;
  endtask
  task automatic test_load_err;
    logic [2:0] f3 [3];
    logic [1:0] off [3];
    f3 = '{3'b010, 3'b101, 3'b001};
    off = '{2'd1, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive(LOAD, f3[i], {30'h0800_0000, off[i]}, 5'd3);
      step;
      drive(NOP, 3'd0, 32'd0, 5'd0);
      mem_rdata = 32'hFFFF_FFFF;
      mem_rvalid = 1'b1;
      step;
      mem_rvalid = 1'b0;
      checks++; if ({stall, rf_wr_en, load_err} !== 3'b001) begin errors++; $display("FAIL misalign[%0d]: got stall/en/err=%b expected 001", i, {stall, rf_wr_en, load_err}); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", load_err); end
    rst_n = 1'b1;
    drive(LOAD, 3'b010, 32'h0800_0000, 5'd2);
    step;
    drive(NOP, 3'd0, 32'd0, 5'd0);
    for (int k = 1; k < 16; k++) begin
      step;
      checks++; if (stall !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL timeout_wait[%0d]: got stall=%b err=%b expected 1/0", k, stall, load_err); end
    end
    step;
    checks++; if ({stall, rf_wr_en, load_err} !== 3'b001) begin errors++; $display("FAIL timeout: got stall/en/err=%b expected 001", {stall, rf_wr_en, load_err}); end
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset_mid_load;
    drive(LOAD, 3'b010, 32'h0000_0100, 5'd6);
    step;
    drive(NOP, 3'd0, 32'd0, 5'd0);
    step;
    checks++; if (stall !== 1'b1 || rf_wr_data !== 32'h0000_0100) begin errors++; $display("FAIL midload_pre: got stall=%b data=%h expected 1/00000100", stall, rf_wr_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({stall, rf_wr_en, load_err, rf_wr_addr, rf_wr_data} !== 40'd0) begin errors++; $display("FAIL midload_rst: got stall=%b en=%b err=%b addr=%h data=%h expected all 0", stall, rf_wr_en, load_err, rf_wr_addr, rf_wr_data); end
    rst_n = 1'b1;
    step;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midload_idle: got stall=%b expected 0", stall); end
  endtask
  task automatic test_halt;
    drive(LOAD, 3'b010, 32'h2000_0004, 5'd12);
    step;
    drive(NOP, 3'd0, 32'd0, 5'd0);
    mem_rdata = 32'hCAFE_F00D;
    halt = 1'b1;
    mem_rvalid = 1'b1;
    step;
    mem_rvalid = 1'b0;
    checks++; if (stall !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL halt_rvalid: got stall=%b en=%b expected 1/0", stall, rf_wr_en); end
    for (int k = 0; k < 20; k++) step;
    checks++; if (stall !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL halt_freeze: got stall=%b err=%b expected 1/0", stall, load_err); end
    halt = 1'b0;
    step;
    checks++; if (stall !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL halt_pending: got stall=%b en=%b expected 1/0", stall, rf_wr_en); end
    mem_rvalid = 1'b1;
    step;
    mem_rvalid = 1'b0;
    checks++; if ({stall, rf_wr_en, rf_wr_addr, rf_wr_data} !== {2'b01, 5'd12, 32'hCAFE_F00D}) begin errors++; $display("FAIL halt_resume: got %b/%b/%0d/%h expected 0/1/12/cafef00d", stall, rf_wr_en, rf_wr_addr, rf_wr_data); end
    step;
  endtask
  task automatic test_csr;
    csr_addr_in = 12'h300;
    csr_data_in = 32'h0F;
    uimm_in = 5'd3;
    drive(SYS, 3'b010, 32'hF0, 5'd4);
    step;
`ifdef WB_CSR_EN
    checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd4, 32'h0F}) begin errors++; $display("FAIL csrrs_rd: got %b/%0d/%h expected 1/4/0000000f", rf_wr_en, rf_wr_addr, rf_wr_data); end
    checks++; if ({csr_wr_en, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h300, 32'hFF}) begin errors++; $display("FAIL csrrs_csr: got %b/%h/%h expected 1/300/000000ff", csr_wr_en, csr_wr_addr, csr_wr_data); end
    uimm_in = 5'd0;
    drive(SYS, 3'b110, 32'hF0, 5'd4);
    step;
    checks++; if (csr_wr_en !== 1'b0 || rf_wr_en !== 1'b1) begin errors++; $display("FAIL csrrsi0: got csr_en=%b rf_en=%b expected 0/1", csr_wr_en, rf_wr_en); end
    csr_data_in = 32'hFF;
    uimm_in = 5'd1;
    drive(SYS, 3'b011, 32'h0F, 5'd4);
    step;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_data !== 32'hF0) begin errors++; $display("FAIL csrrc: got %b/%h expected 1/000000f0", csr_wr_en, csr_wr_data); end
    uimm_in = 5'h1F;
    drive(SYS, 3'b101, 32'h0, 5'd4);
    step;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_data !== 32'h1F) begin errors++; $display("FAIL csrrwi: got %b/%h expected 1/0000001f", csr_wr_en, csr_wr_data); end
    uimm_in = 5'd0;
    drive(SYS, 3'b001, 32'hA5A5_0000, 5'd4);
    step;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_data !== 32'hA5A5_0000) begin errors++; $display("FAIL csrrw: got %b/%h expected 1/a5a50000", csr_wr_en, csr_wr_data); end
    drive(SYS, 3'b000, 32'h1, 5'd4);
    step;
    checks++; if (csr_wr_en !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL sys000: got csr_en=%b rf_en=%b expected 0/0", csr_wr_en, rf_wr_en); end
`else
    checks++; if ({rf_wr_en, csr_wr_en} !== 2'b00) begin errors++; $display("FAIL sys_off_en: got %b expected 00", {rf_wr_en, csr_wr_en}); end
    checks++; if ({csr_wr_addr, csr_wr_data} !== 44'd0) begin errors++; $display("FAIL sys_off_csr: got %h/%h expected 0/0", csr_wr_addr, csr_wr_data); end
`endif
    drive(NOP, 3'd0, 32'd0, 5'd0);
    step;
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_load_err;
    test_reset_mid_load;
    test_halt;
    test_csr;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Single clock clk; reset rst_n is asynchronous and active-low.
REQ-002 Parameter LOAD_TIMEOUT, default 16, is the maximum number of cycles spent waiting for mem_rvalid.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 halt  input  1  freezes the stage.
REQ-006 opcode_in  input  7  opcode from the memory-access stage.
REQ-007 funct3_in  input  3  funct3.
REQ-008 rd_data_in  input  32  ALU result; the load address for LOAD; the rs1 value for SYSTEM.
REQ-009 rd_addr_in  input  5  destination register.
REQ-010 csr_data_in  input  32  current CSR value.
REQ-011 csr_addr_in  input  12  CSR address.
REQ-012 uimm_in  input  5  instruction bits [19:15].
REQ-013 mem_rdata  input  32  data-memory read word.
REQ-014 mem_rvalid  input  1  mem_rdata valid.
REQ-015 rf_wr_en  output  1  register-file write strobe.
REQ-016 rf_wr_addr  output  5  register-file write address.
REQ-017 rf_wr_data  output  32  register-file write data.
REQ-018 csr_wr_en  output  1  CSR write strobe.
REQ-019 csr_wr_addr  output  12  CSR write address.
REQ-020 csr_wr_data  output  32  CSR write data.
REQ-021 stall  output  1  upstream hold request.
REQ-022 load_err  output  1  sticky load-timeout or misalignment flag.

Function
REQ-023 All outputs except stall SHALL be registered; stall SHALL be 1 exactly when the FSM is in WAIT_LOAD.
REQ-024 The FSM SHALL have two states, IDLE and WAIT_LOAD.
REQ-025 In IDLE with halt=0, inputs SHALL be sampled every edge; write strobes SHALL pulse for one cycle in the following cycle.
REQ-026 A sampled LOAD SHALL move the FSM to WAIT_LOAD, latching funct3, rd_addr and address bits [1:0]; inputs presented during WAIT_LOAD SHALL be ignored.
REQ-027 In WAIT_LOAD, mem_rvalid=1 at an edge SHALL produce the formatted rf write in the next cycle and return the FSM to IDLE.
REQ-028 Load format: LB/LH sign-extend, LBU/LHU zero-extend the byte/half at offset addr[1:0]; LW passes the word; any other funct3 SHALL not write.
REQ-029 A misaligned load (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) SHALL suppress the write and set load_err.
REQ-030 A wait counter SHALL count in WAIT_LOAD; reaching LOAD_TIMEOUT without mem_rvalid SHALL set load_err, suppress the write and return to IDLE.
REQ-031 OP, OP-IMM, LUI, AUIPC, JAL and JALR SHALL write rd_data_in; STORE, BRANCH, MISC-MEM and unknown opcodes SHALL not write.
REQ-032 rf_wr_en SHALL never assert for rd_addr=0.
REQ-033 SYSTEM CSR ops: rd gets csr_data_in; new CSR value is RW=src, RS=old|src, RC=old&~src, with src=rs1 value for funct3 001/010/011 and zero-extended uimm_in for 101/110/111.
REQ-034 For RS, RC, RSI and RCI, uimm_in=0 SHALL suppress csr_wr_en; funct3 000 and 100 SHALL write nothing.
REQ-035 halt=1 SHALL deassert both strobes and freeze the FSM, the counter and all latches; mem_rvalid seen during halt SHALL be ignored.

Reset
REQ-036 Asserting rst_n low at any time, including mid-WAIT_LOAD, SHALL immediately clear all outputs, the counter and load_err to 0, set state to IDLE and drop stall.
REQ-037 Deassertion SHALL take effect on the first clk edge after rst_n rises.

Configuration
REQ-038 WB_CSR_EN defined: CSR path per REQ-033/034. Undefined: SYSTEM opcode writes nothing; csr_wr_en, csr_wr_addr and csr_wr_data are tied to 0.

Verification
REQ-039 ADDI result 0x0000_1234, rd=5 -> the next cycle shows rf_wr_en=1, addr 5, data 0x0000_1234; the same instruction with rd=0 -> no write.
REQ-040 LB at addr 0x...2, mem_rdata 0x0080_0000, mem_rvalid after 3 cycles -> stall high for 3 cycles, then data 0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-041 LW at addr 0x...1 -> no write, load_err=1; LW with no mem_rvalid -> load_err=1 after 16 cycles, FSM back in IDLE.
REQ-042 CSRRS with old 0x0F, rs1 0xF0, uimm 3 -> rd gets 0x0F, CSR gets 0xFF; CSRRSI with uimm 0 -> no CSR write.
REQ-043 rst_n pulsed low mid-WAIT_LOAD -> stall and outputs 0 immediately; halt during a load with mem_rvalid pulse -> pulse ignored and the load is still pending.
